// File: rtl/gray_rgb_pkg.sv
// Shared definitions for the gray-to-RGB565 custom instruction.
// Function codes, FSM encoding and the counter saturation helper.
package gray_rgb_pkg;

  localparam logic [1:0] FN_LOAD   = 2'd0;
  localparam logic [1:0] FN_HI     = 2'd1;
  localparam logic [1:0] FN_STATUS = 2'd2;
  localparam logic [1:0] FN_CLEAR  = 2'd3;

  localparam logic [15:0] PIXCOUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Add two pixels to the counter, sticking at the maximum.
  function automatic logic [15:0] sat_add2(input logic [15:0] cnt);
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'd2;
    return sum[16] ? PIXCOUNT_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/gray8_to_rgb565.sv
// Expands one 8-bit gray pixel to RGB565 by truncation.
// All three channels take the top bits of the gray value.
module gray8_to_rgb565 (
  input  logic [7:0]  gray,
  output logic [15:0] rgb
);

  // Pack {R5, G6, B5} straight from the gray MSBs.
  always_comb begin
    rgb = {gray[7:3], gray[7:2], gray[7:3]};
  end

endmodule

// File: rtl/gray_to_rgb565_ise.sv
// Gray-to-RGB565 custom instruction: buffers 4 gray pixels,
// returns them as two RGB565 pairs, counts pixels produced.
module gray_to_rgb565_ise
  import gray_rgb_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_t      state_q, state_d;
  logic [1:0]  fn_q, fn_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] pix_count_q, pix_count_d;
  logic [31:0] res_q, res_d;

  logic [15:0] half_sel;
  logic [15:0] rgb_lo, rgb_hi;
  logic        accept;
  logic        unused_ok;

  assign unused_ok = ^valueB[31:2];

  assign accept = start && (iseId == customInstructionId)
                  && (state_q == IDLE);

  // HI reads the upper gray pair, everything else the lower one.
  always_comb begin
    half_sel = (fn_q == FN_HI) ? buf_q[31:16] : buf_q[15:0];
  end

  gray8_to_rgb565 u_lo (
    .gray (half_sel[7:0]),
    .rgb  (rgb_lo)
  );

  gray8_to_rgb565 u_hi (
    .gray (half_sel[15:8]),
    .rgb  (rgb_hi)
  );

  // Next-state, result and bookkeeping for one CI call.
  always_comb begin
    state_d     = state_q;
    fn_d        = fn_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    pix_count_d = pix_count_q;
    res_d       = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          fn_d    = valueB[1:0];
          if (valueB[1:0] == FN_LOAD) begin
            buf_d       = valueA;
            buf_valid_d = 1'b1;
          end
        end
      end
      EXEC: begin
        state_d = DONE;
        unique case (fn_q)
          FN_LOAD:   res_d = {rgb_hi, rgb_lo};
          FN_HI:     res_d = buf_valid_q ? {rgb_hi, rgb_lo} : 32'd0;
          FN_STATUS: res_d = {15'd0, buf_valid_q, pix_count_q};
          default:   res_d = 32'd0;
        endcase
      end
      DONE: begin
        state_d = IDLE;
        unique case (fn_q)
          FN_LOAD: pix_count_d = sat_add2(pix_count_q);
          FN_HI: begin
            if (buf_valid_q) pix_count_d = sat_add2(pix_count_q);
          end
          FN_CLEAR: begin
            buf_d       = 32'd0;
            buf_valid_d = 1'b0;
            pix_count_d = 16'd0;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fn_q        <= FN_LOAD;
      buf_q       <= 32'd0;
      buf_valid_q <= 1'b0;
      pix_count_q <= 16'd0;
      res_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      fn_q        <= fn_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      pix_count_q <= pix_count_d;
      res_q       <= res_d;
    end
  end

  // Result is only visible during the completion cycle.
  always_comb begin
    done   = (state_q == DONE);
    result = done ? res_q : 32'd0;
  end

endmodule
